// File: rtl/processor_pkg.sv
// Shared processor definitions: register-file geometry and common word types.
package processor_pkg;

    localparam int REG_COUNT  = 16;
    localparam int REG_ADDR_W = 4;
    localparam int DATA_WIDTH = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_COUNT-1:0]  reg_onehot_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/onehot_check.sv
// One-hot qualifier for the register-file write-enable vector.
// Reports whether exactly one bit is set, whether no bit is set, and the
// encoded position of the set bit (only meaningful when valid_o is high).
module onehot_check
    import processor_pkg::*;
(
    input  reg_onehot_t vec_i,
    output logic        valid_o,
    output logic        none_o,
    output reg_addr_t   index_o
);

    logic [4:0] bitCount;

    // Count the set bits and remember the position of the last one seen
    always_comb begin
        bitCount = 5'd0;
        index_o  = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (vec_i[i]) begin
                bitCount = bitCount + 5'd1;
                index_o  = reg_addr_t'(i);
            end
        end
        valid_o = (bitCount == 5'd1);
        none_o  = (bitCount == 5'd0);
    end

endmodule

// File: rtl/register_file_16.sv
// 16-entry register file with a one-hot write port and two registered read
// ports. Multi-hot write vectors are dropped and raise a sticky error flag.
// Optional feature macro: REGFILE_BYPASS_EN (write-first read/write collision);
// when undefined the register file is read-first.
module register_file_16 #(
    parameter int DATA_WIDTH = 16,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           write_onehot,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [3:0]            read_addr_a,
    input  logic [3:0]            read_addr_b,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] read_data_a,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  onehot_err
);

    import processor_pkg::*;

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [DATA_WIDTH-1:0] readA_q, readA_d;
    logic [DATA_WIDTH-1:0] readB_q, readB_d;
    logic                  err_q, err_d;

    logic      wrValid;
    logic      wrNone;
    reg_addr_t wrIndex;
    logic      wrEn;

    onehot_check u_onehot_check (
        .vec_i   (write_onehot),
        .valid_o (wrValid),
        .none_o  (wrNone),
        .index_o (wrIndex)
    );

    // A legal write lands unless it targets a hardwired-zero R0
    assign wrEn = wrValid && !(ZERO_REG && (wrIndex == '0));

    // Next-state storage: only a single-hot, non-discarded write updates a register
    always_comb begin
        regs_d = regs_q;
        if (wrEn) begin
            regs_d[wrIndex] = write_data;
        end
    end

    // Sticky error: a multi-hot vector sets it and beats a simultaneous clear
    always_comb begin
        err_d = err_q;
        if (!wrValid && !wrNone) begin
            err_d = 1'b1;
        end else if (clear_err) begin
            err_d = 1'b0;
        end
    end

    // Read-port next values; bypass reads the post-write array so a colliding
    // legal write is returned, while multi-hot writes never reach regs_d
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        readA_d = regs_d[read_addr_a];
        readB_d = regs_d[read_addr_b];
`else
        readA_d = regs_q[read_addr_a];
        readB_d = regs_q[read_addr_b];
`endif
        if (ZERO_REG && (read_addr_a == '0)) begin
            readA_d = '0;
        end
        if (ZERO_REG && (read_addr_b == '0)) begin
            readB_d = '0;
        end
    end

    // State registers with asynchronous clear of storage, read ports and flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            readA_q <= '0;
            readB_q <= '0;
            err_q   <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            readA_q <= readA_d;
            readB_q <= readB_d;
            err_q   <= err_d;
        end
    end

    assign read_data_a = readA_q;
    assign read_data_b = readB_q;
    assign onehot_err  = err_q;

endmodule
